// File: rtl/ipc_port_arbiter.sv
// rtl/ipc_port_arbiter.sv - round-robin arbiter sharing one IPC input and one IPC output channel
module ipc_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int NUM_DEV = 8,
    parameter int RD_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_write,
    input  logic [NUM_REQ*8-1:0]   req_device_id,
    input  logic [NUM_REQ*32-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_err,
    output logic [7:0]             ipc_out_device_id,
    output logic [31:0]            ipc_out_value,
    output logic                   ipc_wr_en,
    output logic [7:0]             ipc_in_device_id,
    input  logic [31:0]            ipc_in_value
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RD_WAIT + 1);
    localparam logic [8:0] NUM_DEV_W = 9'(NUM_DEV);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   g_q, g_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         out_dev_q, out_dev_d;
    logic [31:0]        out_val_q, out_val_d;
    logic [7:0]         in_dev_q, in_dev_d;

    logic               grant_found;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   cand;
    logic               xfer;
    logic               sel_write;
    logic [7:0]         sel_dev;
    logic [31:0]        sel_wdata;
    logic               dev_err;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !reset && grant_found)
            req_ready = NUM_REQ'(1) << grant_idx;
    end

    assign xfer      = |(req_valid & req_ready);
    assign sel_write = req_write[grant_idx];
    assign sel_dev   = req_device_id[8*grant_idx +: 8];
    assign sel_wdata = req_wdata[32*grant_idx +: 32];
    assign dev_err   = {1'b0, sel_dev} >= NUM_DEV_W;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            g_q       <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            out_dev_q <= '0;
            out_val_q <= '0;
            in_dev_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            g_q       <= g_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            out_dev_q <= out_dev_d;
            out_val_q <= out_val_d;
            in_dev_q  <= in_dev_d;
        end
    end

    // Output channel registers load on the transfer edge so they are valid alongside the strobe
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        g_d       = g_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        out_dev_d = out_dev_q;
        out_val_d = out_val_q;
        in_dev_d  = in_dev_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    g_d     = grant_idx;
                    err_d   = dev_err;
                    rdata_d = '0;
                    if (dev_err) begin
                        state_d = RESP;
                    end else if (sel_write) begin
                        state_d   = WRITE;
                        out_dev_d = sel_dev;
                        out_val_d = sel_wdata;
                    end else begin
                        state_d  = READ;
                        in_dev_d = sel_dev;
                        cnt_d    = CNT_W'(RD_WAIT);
                    end
                end
            end
            WRITE: state_d = RESP;
            READ: begin
                if (cnt_q == '0) begin
                    rdata_d = ipc_in_value;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                rr_ptr_d = (g_q == IDX_W'(NUM_REQ - 1)) ? '0 : g_q + 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rsp_valid = '0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        ipc_wr_en = 1'b0;
        if (state_q == RESP) begin
            rsp_valid = NUM_REQ'(1) << g_q;
            rsp_err   = err_q;
            rsp_rdata = rdata_q;
        end
        if (state_q == WRITE)
            ipc_wr_en = 1'b1;
    end

    assign ipc_out_device_id = out_dev_q;
    assign ipc_out_value     = out_val_q;
    assign ipc_in_device_id  = in_dev_q;
endmodule

// File: tb/tb_ipc_port_arbiter.sv
// tb/tb_ipc_port_arbiter.sv - scoreboard bench for ipc_port_arbiter
module tb_ipc_port_arbiter;
    logic         clk = 1'b0;
    logic         reset, reset3;
    logic [3:0]   req_valid, req_valid3, req_write;
    logic [31:0]  req_device_id;
    logic [127:0] req_wdata;

    logic [3:0]   req_ready, rsp_valid, req_ready3, rsp_valid3;
    logic [31:0]  rsp_rdata, rsp_rdata3, ipc_out_value, ipc_out_value3;
    logic         rsp_err, rsp_err3, ipc_wr_en, ipc_wr_en3;
    logic [7:0]   ipc_out_device_id, ipc_out_device_id3, ipc_in_device_id, ipc_in_device_id3;
    logic [31:0]  ipc_in_value, ipc_in_value3;

    assign ipc_in_value  = 32'h100 + {24'h0, ipc_in_device_id};
    assign ipc_in_value3 = 32'h100 + {24'h0, ipc_in_device_id3};

    ipc_port_arbiter #(.NUM_REQ(4), .NUM_DEV(8), .RD_WAIT(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_device_id(req_device_id), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ipc_out_device_id(ipc_out_device_id), .ipc_out_value(ipc_out_value),
        .ipc_wr_en(ipc_wr_en), .ipc_in_device_id(ipc_in_device_id), .ipc_in_value(ipc_in_value));

    ipc_port_arbiter #(.NUM_REQ(4), .NUM_DEV(8), .RD_WAIT(3)) dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_write(req_write),
        .req_device_id(req_device_id), .req_wdata(req_wdata), .req_ready(req_ready3),
        .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .ipc_out_device_id(ipc_out_device_id3), .ipc_out_value(ipc_out_value3),
        .ipc_wr_en(ipc_wr_en3), .ipc_in_device_id(ipc_in_device_id3), .ipc_in_value(ipc_in_value3));

    always #5 clk = ~clk;

    typedef struct { int idx; logic [31:0] rdata; logic err; int lat; } rsp_t;
    typedef struct { logic [7:0] dev; logic [31:0] val; } wr_t;
    rsp_t exp_q[$];
    wr_t  wr_q[$];
    int   xq[$];
    int   cyc = 0, errors = 0, checks = 0, wr_pulses = 0, rsp3_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (|rsp_valid3) rsp3_pulses++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    // Monitor: sampled 2 time units after the falling edge, clear of the rising edge
    always begin
        rsp_t e;
        wr_t  w;
        int   t;
        @(negedge clk);
        #2;
        if (|(req_valid & req_ready)) xq.push_back(cyc);
        if (|rsp_valid) begin
            if (exp_q.size() == 0) fail("unexpected_rsp");
            else begin
                e = exp_q.pop_front();
                chk("rsp_valid", {28'h0, rsp_valid}, 32'(1) << e.idx);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
                if (xq.size() == 0) fail("rsp_without_xfer");
                else begin
                    t = xq.pop_front();
                    chk("latency", cyc - t, e.lat);
                end
            end
        end
        if (ipc_wr_en) begin
            wr_pulses++;
            if (wr_q.size() == 0) fail("unexpected_wr_en");
            else begin
                w = wr_q.pop_front();
                chk("ipc_out_device_id", {24'h0, ipc_out_device_id}, {24'h0, w.dev});
                chk("ipc_out_value", ipc_out_value, w.val);
            end
        end
    end

    task automatic set_cmd(input int i, input logic w, input logic [7:0] dev, input logic [31:0] data);
        req_write[i] = w;
        req_device_id[8*i +: 8] = dev;
        req_wdata[32*i +: 32] = data;
    endtask

    task automatic exp_rsp(input int idx, input logic [31:0] rdata, input logic err, input int lat);
        rsp_t e;
        e.idx = idx; e.rdata = rdata; e.err = err; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic exp_wr(input logic [7:0] dev, input logic [31:0] val);
        wr_t w;
        w.dev = dev; w.val = val;
        wr_q.push_back(w);
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer
    task automatic wait_xfer(input int which, input int i, input bit drop, output int c, output logic [3:0] rdy);
        int n = 0;
        #2;
        while (!(which != 0 ? req_ready3[i] : req_ready[i]) && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (n >= 50) fail("grant_timeout");
        c = cyc;
        rdy = (which != 0) ? req_ready3 : req_ready;
        @(negedge clk);
        if (drop) begin
            if (which != 0) req_valid3[i] = 1'b0;
            else req_valid[i] = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || wr_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || wr_q.size() != 0) fail("drain_timeout");
        @(negedge clk);
    endtask

    task automatic d3_txn(input int i, input logic [3:0] extra, input logic [31:0] exp_rdata, input logic [3:0] exp_rdy);
        int c, n;
        logic [3:0] rdy;
        @(negedge clk);
        req_valid3 = req_valid3 | extra;
        req_valid3[i] = 1'b1;
        wait_xfer(1, i, 1'b1, c, rdy);
        chk("d3_grant", {28'h0, rdy}, {28'h0, exp_rdy});
        n = 0;
        #2;
        while (!(|rsp_valid3) && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("d3_rsp_valid", {28'h0, rsp_valid3}, 32'(1) << i);
        chk("d3_rsp_rdata", rsp_rdata3, exp_rdata);
        chk("d3_latency", cyc - c, 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, c2, wp;
        logic [3:0] rdy;
        reset = 1'b1; reset3 = 1'b1;
        req_valid = 4'hF; req_valid3 = 4'h0; req_write = 4'h0;
        req_device_id = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_ready", {28'h0, req_ready}, 0);
        chk("rst_rsp_valid", {28'h0, rsp_valid}, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 0);
        chk("rst_ipc_out_device_id", {24'h0, ipc_out_device_id}, 0);
        chk("rst_ipc_out_value", ipc_out_value, 0);
        chk("rst_ipc_wr_en", {31'h0, ipc_wr_en}, 0);
        chk("rst_ipc_in_device_id", {24'h0, ipc_in_device_id}, 0);
        @(negedge clk);
        req_valid = 4'h0;
        reset = 1'b0;

        // write dev 3 from requester 0
        set_cmd(0, 1'b1, 8'd3, 32'hDEADBEEF);
        exp_wr(8'd3, 32'hDEADBEEF);
        exp_rsp(0, 32'h0, 1'b0, 2);
        req_valid[0] = 1'b1;
        wait_xfer(0, 0, 1'b1, c0, rdy);
        drain();

        // read dev 5 from requester 2
        set_cmd(2, 1'b0, 8'd5, 32'h0);
        exp_rsp(2, 32'h105, 1'b0, 3);
        req_valid[2] = 1'b1;
        wait_xfer(0, 2, 1'b1, c0, rdy);
        drain();
        chk("ipc_in_device_id_hold", {24'h0, ipc_in_device_id}, 5);

        // out-of-range write leaves the output channel untouched
        set_cmd(1, 1'b1, 8'd9, 32'h12345678);
        exp_rsp(1, 32'h0, 1'b1, 1);
        req_valid[1] = 1'b1;
        wait_xfer(0, 1, 1'b1, c0, rdy);
        drain();
        chk("oor_out_dev_kept", {24'h0, ipc_out_device_id}, 3);
        chk("oor_out_val_kept", ipc_out_value, 32'hDEADBEEF);

        // four simultaneous reads from reset, then 0 and 3 together
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_cmd(i, 1'b0, 8'(i), 32'h0);
            exp_rsp(i, 32'h100 + 32'(i), 1'b0, 3);
        end
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) wait_xfer(0, i, 1'b1, c0, rdy);
        drain();
        exp_rsp(0, 32'h100, 1'b0, 3);
        exp_rsp(3, 32'h103, 1'b0, 3);
        req_valid = 4'b1001;
        wait_xfer(0, 0, 1'b1, c0, rdy);
        chk("rr_wrap_grant", {28'h0, rdy}, 32'h1);
        wait_xfer(0, 3, 1'b1, c0, rdy);
        drain();

        // back-to-back writes with req_valid held
        wp = wr_pulses;
        set_cmd(1, 1'b1, 8'd4, 32'd1);
        for (int v = 1; v <= 3; v++) begin
            exp_wr(8'd4, 32'(v));
            exp_rsp(1, 32'h0, 1'b0, 2);
        end
        req_valid[1] = 1'b1;
        wait_xfer(0, 1, 1'b0, c0, rdy);
        req_wdata[63:32] = 32'd2;
        wait_xfer(0, 1, 1'b0, c1, rdy);
        req_wdata[63:32] = 32'd3;
        wait_xfer(0, 1, 1'b1, c2, rdy);
        drain();
        chk("b2b_gap1", c1 - c0, 3);
        chk("b2b_gap2", c2 - c1, 3);
        chk("b2b_wr_pulses", wr_pulses - wp, 3);

        // reset mid-read on the RD_WAIT=3 instance
        @(negedge clk);
        reset3 = 1'b0;
        set_cmd(2, 1'b0, 8'd6, 32'h0);
        set_cmd(3, 1'b0, 8'd7, 32'h0);
        set_cmd(0, 1'b0, 8'd1, 32'h0);
        d3_txn(2, 4'h0, 32'h106, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        rsp3_pulses = 0;
        req_valid3[3] = 1'b1;
        wait_xfer(1, 3, 1'b1, c0, rdy);
        @(negedge clk);
        reset3 = 1'b1;
        @(negedge clk);
        reset3 = 1'b0;
        #2;
        chk("mid_rst_req_ready", {28'h0, req_ready3}, 0);
        chk("mid_rst_rsp_valid", {28'h0, rsp_valid3}, 0);
        chk("mid_rst_rsp_rdata", rsp_rdata3, 0);
        chk("mid_rst_rsp_err", {31'h0, rsp_err3}, 0);
        chk("mid_rst_out_dev", {24'h0, ipc_out_device_id3}, 0);
        chk("mid_rst_out_val", ipc_out_value3, 0);
        chk("mid_rst_wr_en", {31'h0, ipc_wr_en3}, 0);
        chk("mid_rst_in_dev", {24'h0, ipc_in_device_id3}, 0);
        repeat (8) @(negedge clk);
        chk("mid_rst_no_rsp", rsp3_pulses, 0);
        d3_txn(0, 4'b1000, 32'h101, 4'b0001);
        d3_txn(3, 4'h0, 32'h107, 4'b1000);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
